// File: rtl/mc_if.sv
// Control bus between the multicycle controller and its datapath.
// slave: the controller side; master: the datapath (or a bench standing in for it).
interface mc_if;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite;
  logic        MemWrite;
  logic        RegWrite;
  logic        IRWrite;
  logic        AdrSrc;
  logic [1:0]  RegSrc;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ResultSrc;
  logic [1:0]  ImmSrc;
  logic [2:0]  ALUControl;
  logic [3:0]  State;
  logic [3:0]  Flags;

  modport slave (
    input  Instr, ALUFlags,
    output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, State, Flags
  );

  modport master (
    output Instr, ALUFlags,
    input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, State, Flags
  );
endinterface

// File: rtl/mc_controller.sv
// Multicycle ARM-subset control unit: Moore FSM, instruction decoder and
// NZCV condition unit. Architectural writes are gated by the condition
// result captured at the end of DECODE.
module mc_controller #(
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic clk,
  input  logic reset,   // active low, asynchronous
  mc_if.slave  bus
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXECR  = 4'd6;
  localparam logic [3:0] S_EXECI  = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BR1    = 4'd9;
  localparam logic [3:0] S_BR2    = 4'd10;
  localparam logic [3:0] S_BR3    = 4'd11;

  logic [3:0] state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       condex_q, condex_d;
  logic       condex;

  // ---- decode ----
  logic [1:0] op;
  logic [3:0] cmd;
  logic       f_i, f_s, f_l, f_u;
  logic       is_dp, is_mem, is_br;
  logic       c_add, c_sub, c_and, c_orr, c_cmp, c_nop;
  logic [2:0] dp_alu;

  assign op     = bus.Instr[27:26];
  assign f_i    = bus.Instr[25];
  assign cmd    = bus.Instr[24:21];
  assign f_u    = bus.Instr[23];
  assign f_s    = bus.Instr[20];
  assign f_l    = bus.Instr[20];
  assign is_dp  = (op == 2'b00);
  assign is_mem = (op == 2'b01);
  assign is_br  = (op == 2'b10);

  assign c_add = (cmd == 4'b0100);
  assign c_sub = (cmd == 4'b0010);
  assign c_and = (cmd == 4'b0000);
  assign c_orr = (cmd == 4'b1100);
  assign c_cmp = (cmd == 4'b1010);
  assign c_nop = !(c_add | c_sub | c_and | c_orr | c_cmp);

  // Register/immediate fields are consumed by the datapath, not here.
  logic unused_instr;
  assign unused_instr = &{1'b0, bus.Instr[19:0]};

  // DP opcode to ALU control; unsupported commands fall back to ADD (no writes anyway)
  always_comb begin
    dp_alu = 3'b000;
    if (c_sub | c_cmp) dp_alu = 3'b001;
    else if (c_and)    dp_alu = 3'b010;
    else if (c_orr)    dp_alu = 3'b011;
  end

  // ---- condition unit: evaluate cond field against the held NZCV ----
  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = flags_q;
    case (bus.Instr[31:28])
      4'h0: condex = z;
      4'h1: condex = !z;
      4'h2: condex = c;
      4'h3: condex = !c;
      4'h4: condex = n;
      4'h5: condex = !n;
      4'h6: condex = v;
      4'h7: condex = !v;
      4'h8: condex = c & !z;
      4'h9: condex = !c | z;
      4'hA: condex = (n == v);
      4'hB: condex = (n != v);
      4'hC: condex = !z & (n == v);
      4'hD: condex = z | (n != v);
      4'hE: condex = 1'b1;
      default: condex = 1'b0;
    endcase
  end

  // Next-state, condex capture and flag update
  always_comb begin
    state_d  = S_FETCH;
    condex_d = condex_q;
    flags_d  = flags_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        condex_d = condex;
        if (is_mem)     state_d = S_MEMADR;
        else if (is_dp) state_d = f_i ? S_EXECI : S_EXECR;
        else if (is_br) state_d = S_BR1;
        else            state_d = S_FETCH;
      end
      S_MEMADR: state_d = f_l ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXECR,
      S_EXECI: begin
        state_d = S_ALUWB;
        if (condex_q && (f_s || c_cmp) && !c_nop) begin
          flags_d[3:2] = bus.ALUFlags[3:2];
          // logical ops leave C and V alone
          if (c_add | c_sub | c_cmp) flags_d[1:0] = bus.ALUFlags[1:0];
        end
      end
      S_BR1:    state_d = S_BR2;
      S_BR2:    state_d = S_BR3;
      default:  state_d = S_FETCH;
    endcase
  end

  // State, flags and latched condition; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_FETCH;
      flags_q  <= FLAGS_RST;
      condex_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      flags_q  <= flags_d;
      condex_q <= condex_d;
    end
  end

  // Moore control outputs; write enables are held off while reset is low
  always_comb begin
    logic pcw, memw, regw, irw;
    pcw  = 1'b0;
    memw = 1'b0;
    regw = 1'b0;
    irw  = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.ALUSrcA    = 2'b00;
    bus.ALUSrcB    = 2'b00;
    bus.ResultSrc  = 2'b00;
    bus.ALUControl = 3'b000;
    case (state_q)
      S_FETCH:  begin irw = 1'b1; bus.ALUSrcA = 2'b01; bus.ALUSrcB = 2'b10; end
      S_DECODE: begin
        pcw = 1'b1; bus.ALUSrcA = 2'b01; bus.ALUSrcB = 2'b10; bus.ResultSrc = 2'b10;
      end
      S_MEMADR: begin bus.ALUSrcB = 2'b01; bus.ALUControl = f_u ? 3'b000 : 3'b001; end
      S_MEMRD:  bus.AdrSrc = 1'b1;
      S_MEMWB:  begin bus.ResultSrc = 2'b01; regw = condex_q; end
      S_MEMWR:  begin bus.AdrSrc = 1'b1; memw = condex_q; end
      S_EXECR:  bus.ALUControl = dp_alu;
      S_EXECI:  begin bus.ALUSrcB = 2'b01; bus.ALUControl = dp_alu; end
      S_ALUWB:  regw = condex_q & !c_cmp & !c_nop;
      S_BR1:    begin bus.ALUSrcA = 2'b01; bus.ALUSrcB = 2'b10; bus.ResultSrc = 2'b10; end
      S_BR2:    bus.ALUSrcB = 2'b01;
      S_BR3:    pcw = condex_q;
      default:  ;
    endcase
    bus.PCWrite  = reset & pcw;
    bus.MemWrite = reset & memw;
    bus.RegWrite = reset & regw;
    bus.IRWrite  = reset & irw;
  end

  assign bus.RegSrc = {is_mem & !f_l, is_br};
  assign bus.ImmSrc = (op == 2'b11) ? 2'b00 : op;
  assign bus.State  = state_q;
  assign bus.Flags  = flags_q;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: a per-instruction reference model
// pushes the expected cycle-by-cycle controls, a monitor pops and compares.
module tb_mc_controller;
  localparam logic [3:0] FLAGS_RST = 4'b0000;

  logic clk = 1'b0;
  logic reset;
  mc_if bus();

  mc_controller #(.FLAGS_RST(FLAGS_RST)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, memw, regw, irw, adr;
    logic [1:0] srca, srcb, rsrc, regsrc, immsrc;
    logic [2:0] alu;
    logic       alu_chk;
    logic [3:0] flg;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  logic [3:0] mflags;
  bit   done = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // ARM condition codes over {N,Z,C,V}
  function automatic bit cond_ok(input logic [3:0] cc, input logic [3:0] f);
    bit n, z, c, v;
    {n, z, c, v} = f;
    case (cc)
      0: return z;          1: return !z;
      2: return c;          3: return !c;
      4: return n;          5: return !n;
      6: return v;          7: return !v;
      8: return c && !z;    9: return !c || z;
      10: return n == v;    11: return n != v;
      12: return !z && n == v;
      13: return z || n != v;
      14: return 1;
      default: return 0;
    endcase
  endfunction

  // Expected controls for one cycle of an instruction in state s
  function automatic exp_t mk(input int s, input logic [31:0] ins, input bit c,
                              input logic [3:0] f, input bit rst);
    exp_t e;
    logic [1:0] op;
    logic [3:0] cmd;
    bit writes, isnop;
    op = ins[27:26];
    cmd = ins[24:21];
    writes = (cmd == 4) || (cmd == 2) || (cmd == 0) || (cmd == 12);
    isnop  = !writes && (cmd != 10);
    e = '0;
    e.st   = rst ? 4'd0 : 4'(s);
    e.flg  = f;
    e.regsrc = {op == 2'b01 && !ins[20], op == 2'b10};
    e.immsrc = (op == 2'b11) ? 2'b00 : op;
    e.alu_chk = 1;
    if (rst || s == 0 || s == 1 || s == 9) begin e.srca = 2'b01; e.srcb = 2'b10; end
    if (s == 2 || s == 7 || s == 10) e.srcb = 2'b01;
    if (rst) return e;
    e.irw  = (s == 0);
    e.pcw  = (s == 1) || (s == 11 && c);
    e.memw = (s == 5 && c);
    e.regw = (s == 4 && c) || (s == 8 && c && writes);
    e.adr  = (s == 3) || (s == 5);
    e.rsrc = (s == 1 || s == 9) ? 2'b10 : (s == 4) ? 2'b01 : 2'b00;
    if (s == 2) e.alu = ins[23] ? 3'd0 : 3'd1;
    if (s == 6 || s == 7) begin
      case (cmd)
        4: e.alu = 3'd0;
        2, 10: e.alu = 3'd1;
        0: e.alu = 3'd2;
        12: e.alu = 3'd3;
        default: e.alu_chk = 0;
      endcase
      if (isnop) e.alu_chk = 0;
    end
    return e;
  endfunction

  // Runs one instruction starting in FETCH (called at posedge+1).
  // abort_at >= 0 asserts reset on that step instead of executing it.
  task automatic run_instr(input logic [31:0] ins, input int abort_at,
                           input bit use_fx, input logic [3:0] fx);
    int seq[$];
    bit c;
    logic [3:0] cmd;
    logic [3:0] fl;
    cmd = ins[24:21];
    case (ins[27:26])
      2'b00: seq = ins[25] ? '{0, 1, 7, 8} : '{0, 1, 6, 8};
      2'b01: seq = ins[20] ? '{0, 1, 2, 3, 4} : '{0, 1, 2, 5};
      2'b10: seq = '{0, 1, 9, 10, 11};
      default: seq = '{0, 1};
    endcase
    c = cond_ok(ins[31:28], mflags);
    for (int k = 0; k < seq.size(); k++) begin
      if (k == abort_at) begin
        reset = 1'b0;
        #1;
        mflags = FLAGS_RST;
        sbq.push_back(mk(0, ins, 0, mflags, 1));
        @(posedge clk); #1;
        sbq.push_back(mk(0, ins, 0, mflags, 1));
        @(posedge clk); #1;
        reset = 1'b1;
        return;
      end
      fl = use_fx ? fx : 4'($urandom);
      bus.Instr = ins;
      bus.ALUFlags = fl;
      sbq.push_back(mk(seq[k], ins, c, mflags, 0));
      if ((seq[k] == 6 || seq[k] == 7) && c && (ins[20] || cmd == 10)) begin
        if (cmd == 4 || cmd == 2 || cmd == 10) mflags = fl;
        else if (cmd == 0 || cmd == 12) mflags[3:2] = fl[3:2];
      end
      @(posedge clk); #1;
    end
  endtask

  // Monitor: compare whatever the DUT presents against the oldest expectation
  initial begin
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("State", bus.State, e.st);
        chk("PCWrite", bus.PCWrite, e.pcw);
        chk("MemWrite", bus.MemWrite, e.memw);
        chk("RegWrite", bus.RegWrite, e.regw);
        chk("IRWrite", bus.IRWrite, e.irw);
        chk("AdrSrc", bus.AdrSrc, e.adr);
        chk("ALUSrcA", bus.ALUSrcA, e.srca);
        chk("ALUSrcB", bus.ALUSrcB, e.srcb);
        chk("ResultSrc", bus.ResultSrc, e.rsrc);
        chk("RegSrc", bus.RegSrc, e.regsrc);
        chk("ImmSrc", bus.ImmSrc, e.immsrc);
        if (e.alu_chk) chk("ALUControl", bus.ALUControl, e.alu);
        chk("Flags", bus.Flags, e.flg);
      end
    end
  end

  initial begin
    logic [31:0] ins;
    logic [3:0]  dpcmds [5];
    dpcmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
    mflags = FLAGS_RST;
    reset = 1'b0;
    bus.Instr = 32'h0;
    bus.ALUFlags = 4'h0;
    @(posedge clk); #1;
    sbq.push_back(mk(0, bus.Instr, 0, mflags, 1));
    @(posedge clk); #1;
    sbq.push_back(mk(0, bus.Instr, 0, mflags, 1));
    @(posedge clk); #1;
    reset = 1'b1;

    run_instr(32'hE3520005, -1, 1, 4'b0110);  // CMP R2,#5 -> Flags 0110
    run_instr(32'hE0821003, 2, 0, 4'h0);      // ADD aborted in EXECR by reset
    run_instr(32'hE0821003, -1, 0, 4'h0);     // ADD R1,R2,R3
    run_instr(32'hE5921004, -1, 0, 4'h0);     // LDR R1,[R2,#4]
    run_instr(32'h05821000, -1, 0, 4'h0);     // STREQ with Z=0
    run_instr(32'h0A000002, -1, 0, 4'h0);     // BEQ not taken
    run_instr(32'hE3520005, -1, 1, 4'b0100);  // CMP sets Z=1
    run_instr(32'h0A000002, -1, 0, 4'h0);     // BEQ taken
    run_instr(32'hFE000000, -1, 0, 4'h0);     // undefined op, cond 1111

    for (int n = 0; n < 300; n++) begin
      ins = $urandom;
      if ($urandom_range(0, 3) == 0) ins[31:28] = 4'hE;
      if (ins[27:26] == 2'b00 && $urandom_range(0, 4) != 0)
        ins[24:21] = dpcmds[$urandom_range(0, 4)];
      run_instr(ins, ($urandom_range(0, 40) == 0) ? 2 : -1, 0, 4'h0);
    end

    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("scoreboard_drained", sbq.size(), 0);
    done = 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
